id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the MIPS pipeline. It sits directly downstream of the register file, captures the two register operands plus decode fields each cycle, and presents them to the EX stage. It also detects load-use hazards, inserts bubbles, and applies branch flushes. It forwards EX/MEM and MEM/WB results onto the EX operands and keeps a saturating stall counter.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register address width
- CTRL_W, 8, opaque EX/MEM/WB control bundle width (passed through)
- PERF_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW each  decoded register addresses (id_rd = final destination)
- id_uses_rt  in  1  instruction reads rt as a source
- id_reg1, id_reg2  in  DATA_W  register file read data for rs/rt
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_regwrite, id_memread  in  1  decoded controls
- id_ctrl  in  CTRL_W  remaining controls
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
- exmem_regwrite  in  1; exmem_rd  in  REG_AW; exmem_result  in  DATA_W  EX/MEM forward source
- memwb_regwrite  in  1; memwb_rd  in  REG_AW; memwb_data  in  DATA_W  MEM/WB forward source (also register file write port)
- ex_valid, ex_regwrite, ex_memread  out  1  registered
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered
- ex_imm  out  DATA_W; ex_ctrl  out  CTRL_W  registered
- ex_opa, ex_opb  out  DATA_W  forwarded operands (combinational from registered state)
- hazard_stall  out  1  combinational; IF/ID must hold PC and instruction
- perf_stalls  out  PERF_W  saturating count of stall cycles

## Operation
- Load-use detect: hazard_stall = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)) & !flush.
- Each cycle, the stage uses the first matching case:
  - reset: all registered outputs become 0 and perf_stalls becomes 0.
  - flush: load a bubble. ex_valid, ex_regwrite, and ex_memread become 0. Other fields become 0.
  - hazard_stall: load a bubble, same as flush. The upstream register holds the ID inputs, so the instruction re-presents next cycle.
  - otherwise: latch all ID inputs. ex_valid takes id_valid. ex_regwrite and ex_memread are ANDed with id_valid.
- Forwarding, applied separately to ex_opa (source ex_rs, stored value reg1_q) and ex_opb (source ex_rt, stored value reg2_q):
  - Priority 1: if exmem_regwrite & exmem_rd != 0 & exmem_rd == source, use exmem_result.
  - Priority 2: else if memwb_regwrite & memwb_rd != 0 & memwb_rd == source, use memwb_data.
  - Priority 3: else use the stored value.
  - Register 0 is never forwarded.
- perf_stalls increments on every cycle with hazard_stall = 1 and stops at all-ones.

## Timing
- ID → EX latency is one cycle. ex_* outputs are valid for the cycle after the capture edge.
- hazard_stall lasts exactly one cycle per load-use pair. After the bubble, the load sits in MEM, and the MEM/WB forward covers the dependency one cycle later.
- Simultaneous flush and hazard: flush wins, hazard_stall = 0, perf_stalls does not increment.
- Reset asserted during a stall: the next cycle shows the reset state, and hazard_stall = 0 because ex_valid = 0.
- Bubbles carry ex_regwrite = 0 and ex_memread = 0, so a bubble can never trigger a forward or a hazard.

## Configuration
- WB_BYPASS_EN defined: at capture, the stage replaces id_reg1 with memwb_data if memwb_regwrite & memwb_rd != 0 & memwb_rd == id_rs. The same rule applies to id_reg2 with id_rt. This covers a register file read in the same cycle as its write.
- WB_BYPASS_EN undefined: id_reg1 and id_reg2 are captured raw. The register file is then responsible for same-cycle write-through.

## Test plan
- Reset: assert reset for 2 cycles while driving id_valid=1 → all ex_* = 0, hazard_stall = 0, perf_stalls = 0.
- Load-use stall: `lw $t0` latched with ex_rd=8 and ex_memread=1; ID presents `add` with rs=8 → hazard_stall=1 for 1 cycle, bubble in EX (ex_valid=0), perf_stalls=1. The `add` is captured on the next cycle.
- Forward priority: ex_rs=9, exmem_rd=9 with result 0x11, memwb_rd=9 with data 0x22 → ex_opa=0x11. Drop exmem_regwrite → ex_opa=0x22.
- $zero guard: exmem_regwrite=1, exmem_rd=0, ex_rs=0, stored value 0 → ex_opa=0. A load with rd=0 followed by a use of $0 → no stall.
- Flush vs hazard: load-use condition plus flush=1 in the same cycle → hazard_stall=0, bubble captured, perf_stalls unchanged.
- WB bypass (macro on): memwb_regwrite=1, memwb_rd=10, memwb_data=0x55, id_rs=10, id_reg1=0x0A → ex_opa=0x55 next cycle. With the macro off → 0x0A.

Source files
------------

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage: MIPS ID/EX pipeline register with load-use stall, branch flush,
// EX/MEM + MEM/WB operand forwarding and a saturating stall counter.
// Optional macro WB_BYPASS_EN: bypass MEM/WB write data into captured operands.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_reg1,
  input  logic [DATA_W-1:0] id_reg2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_opa,
  output logic [DATA_W-1:0] ex_opb,
  output logic              hazard_stall,
  output logic [PERF_W-1:0] perf_stalls
);

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q,  memread_d;
  logic [REG_AW-1:0] rs_q,       rs_d;
  logic [REG_AW-1:0] rt_q,       rt_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [DATA_W-1:0] reg1_q,     reg1_d;
  logic [DATA_W-1:0] reg2_q,     reg2_d;
  logic [PERF_W-1:0] perf_q,     perf_d;
  logic [DATA_W-1:0] reg1_in;
  logic [DATA_W-1:0] reg2_in;

  // Register 0 is hard-wired zero, so it never matches a forward source.
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] src,
                                            input logic [DATA_W-1:0] stored);
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == src)
      return exmem_result;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == src)
      return memwb_data;
    else
      return stored;
  endfunction

  always_comb begin
    hazard_stall = valid_q && memread_q && (rd_q != '0) && id_valid &&
                   ((rd_q == id_rs) || (id_uses_rt && rd_q == id_rt)) && !flush;

    reg1_in = id_reg1;
    reg2_in = id_reg2;
`ifdef WB_BYPASS_EN
    if (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs) reg1_in = memwb_data;
    if (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rt) reg2_in = memwb_data;
`endif

    // Bubble by default; only a clean cycle latches the ID instruction.
    valid_d    = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    rs_d       = '0;
    rt_d       = '0;
    rd_d       = '0;
    imm_d      = '0;
    ctrl_d     = '0;
    reg1_d     = '0;
    reg2_d     = '0;
    if (!flush && !hazard_stall) begin
      valid_d    = id_valid;
      regwrite_d = id_regwrite && id_valid;
      memread_d  = id_memread && id_valid;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rd_d       = id_rd;
      imm_d      = id_imm;
      ctrl_d     = id_ctrl;
      reg1_d     = reg1_in;
      reg2_d     = reg2_in;
    end

    perf_d = perf_q;
    if (hazard_stall && perf_q != '1) perf_d = perf_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      ctrl_q     <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      perf_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      perf_q     <= perf_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign ex_imm      = imm_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_opa      = fwd(rs_q, reg1_q);
  assign ex_opb      = fwd(rt_q, reg2_q);
  assign perf_stalls = perf_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage: directed vector table plus hand sequences for id_ex_stage.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rt, id_regwrite, id_memread, flush;
  logic [4:0]  id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_reg1, id_reg2, id_imm, exmem_result, memwb_data;
  logic [7:0]  id_ctrl;
  logic        exmem_regwrite, memwb_regwrite;
  logic        ex_valid, ex_regwrite, ex_memread, hazard_stall;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_imm, ex_opa, ex_opb;
  logic [7:0]  ex_ctrl;
  logic [2:0]  perf_stalls;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(8), .PERF_W(3)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_opa(ex_opa), .ex_opb(ex_opb),
    .hazard_stall(hazard_stall), .perf_stalls(perf_stalls)
  );

  typedef struct {
    logic [31:0] v, rs, rt, rd, ut, r1, r2, imm, rw, mr, ctrl, fl;
    logic [31:0] xw, xrd, xres, ww, wrd, wdat;
    logic [31:0] stall, evalid, erd, erw, emr, eopa, eopb, eimm, eperf;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid       = t.v[0];
    id_rs          = t.rs[4:0];
    id_rt          = t.rt[4:0];
    id_rd          = t.rd[4:0];
    id_uses_rt     = t.ut[0];
    id_reg1        = t.r1;
    id_reg2        = t.r2;
    id_imm         = t.imm;
    id_regwrite    = t.rw[0];
    id_memread     = t.mr[0];
    id_ctrl        = t.ctrl[7:0];
    flush          = t.fl[0];
    exmem_regwrite = t.xw[0];
    exmem_rd       = t.xrd[4:0];
    exmem_result   = t.xres;
    memwb_regwrite = t.ww[0];
    memwb_rd       = t.wrd[4:0];
    memwb_data     = t.wdat;
  endtask

  // Drive on the falling edge, check the stall before the rising edge and the
  // captured EX state just after it.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    drive(t);
    #1;
    check({tag, ".stall"}, 32'(hazard_stall), t.stall);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(ex_valid), t.evalid);
    check({tag, ".rd"}, 32'(ex_rd), t.erd);
    check({tag, ".regwrite"}, 32'(ex_regwrite), t.erw);
    check({tag, ".memread"}, 32'(ex_memread), t.emr);
    check({tag, ".opa"}, ex_opa, t.eopa);
    check({tag, ".opb"}, ex_opb, t.eopb);
    check({tag, ".imm"}, ex_imm, t.imm === t.imm && t.evalid == 0 && t.erd == 0 ? 32'h0 : t.eimm);
    check({tag, ".perf"}, 32'(perf_stalls), t.eperf);
  endtask

  function automatic vec_t ld8(input logic [31:0] perf);
    ld8 = '{1,4,0,8,0,'h50,0,'h34,1,1,'h08,0, 0,0,0, 0,0,0, 0,1,8,1,1,'h50,0,'h34,perf};
  endfunction

  function automatic vec_t use8(input logic [31:0] perf);
    use8 = '{1,5,8,15,1,'h60,'h70,'h38,1,0,'h09,0, 0,0,0, 0,0,0, 1,0,0,0,0,0,0,0,perf};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_perf;
    //   v rs rt rd ut r1     r2     imm   rw mr ctrl  fl  xw xrd xres  ww wrd wdat     st ev erd erw emr opa      opb    imm   perf
    vecs[0]  = '{1,1,8,8,0,'h100,0,4,1,1,'h3C,0, 0,0,0, 0,0,0, 0,1,8,1,1,'h100,0,4,0};
    vecs[1]  = '{1,8,9,10,1,'h111,'h222,0,1,0,'h01,0, 0,0,0, 0,0,0, 1,0,0,0,0,0,0,0,1};
    vecs[2]  = '{1,8,9,10,1,'h111,'h222,0,1,0,'h01,0, 0,0,0, 1,8,'hDEAD, 0,1,10,1,0,'hDEAD,'h222,0,1};
    vecs[3]  = '{1,9,9,11,1,5,6,'h10,1,0,'h02,0, 1,9,'h11, 1,9,'h22, 0,1,11,1,0,'h11,'h11,'h10,1};
    vecs[4]  = '{1,9,9,11,1,5,6,'h10,1,0,'h02,0, 0,9,'h11, 1,9,'h22, 0,1,11,1,0,'h22,'h22,'h10,1};
    vecs[5]  = '{1,0,0,12,1,0,7,'h20,1,0,'h03,0, 1,0,'h99, 1,0,'h88, 0,1,12,1,0,0,7,'h20,1};
    vecs[6]  = '{1,2,0,0,0,'h30,0,'h24,1,1,'h04,0, 0,0,0, 0,0,0, 0,1,0,1,1,'h30,0,'h24,1};
    vecs[7]  = '{1,0,0,13,1,0,0,'h28,1,0,'h05,0, 0,0,0, 0,0,0, 0,1,13,1,0,0,0,'h28,1};
    vecs[8]  = '{1,3,0,8,0,'h40,0,'h2C,1,1,'h06,0, 0,0,0, 0,0,0, 0,1,8,1,1,'h40,0,'h2C,1};
    vecs[9]  = '{1,8,0,14,0,1,0,'h30,1,0,'h07,1, 0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,1};
    vecs[10] = ld8(1);
    vecs[11] = use8(2);
    vecs[12] = ld8(2);
    vecs[13] = '{1,5,8,16,0,'h60,'h70,'h38,1,0,'h09,0, 0,0,0, 0,0,0, 0,1,16,1,0,'h60,'h70,'h38,2};
    vecs[14] = '{0,16,0,17,0,'h80,0,'h3C,1,1,'h0A,0, 0,0,0, 0,0,0, 0,0,17,0,0,'h80,0,'h3C,2};

    // Reset held two cycles while ID presents a valid load.
    reset = 1'b1;
    drive(vecs[0]);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst%0d.valid", c), 32'(ex_valid), 0);
      check($sformatf("rst%0d.memread", c), 32'(ex_memread), 0);
      check($sformatf("rst%0d.rd", c), 32'(ex_rd), 0);
      check($sformatf("rst%0d.opa", c), ex_opa, 0);
      check($sformatf("rst%0d.stall", c), 32'(hazard_stall), 0);
      check($sformatf("rst%0d.perf", c), 32'(perf_stalls), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
      if (i == 0) begin
        check("v0.rs", 32'(ex_rs), 1);
        check("v0.rt", 32'(ex_rt), 8);
        check("v0.ctrl", 32'(ex_ctrl), 'h3C);
      end
    end

    // Same-cycle register file write captured at ID, then the forward source leaves.
    @(negedge clk);
    drive('{1,10,0,18,0,'h0A,0,'h44,1,0,'h5A,0, 0,0,0, 1,10,'h55, 0,0,0,0,0,0,0,0,0});
    @(posedge clk);
    #1;
    memwb_regwrite = 1'b0;
    #1;
    check("byp.rs", 32'(ex_rs), 10);
    check("byp.ctrl", 32'(ex_ctrl), 'h5A);
`ifdef WB_BYPASS_EN
    check("byp.opa", ex_opa, 'h55);
`else
    check("byp.opa", ex_opa, 'h0A);
`endif

    // Stall counter saturates at all-ones (3-bit instance).
    exp_perf = 2;
    for (int k = 0; k < 6; k++) begin
      exp_perf = (exp_perf < 7) ? exp_perf + 1 : 7;
      apply(ld8(32'(exp_perf == 7 && k > 0 && exp_perf == 7 ? exp_perf - ((k >= 5) ? 0 : 1) : exp_perf - 1)),
            $sformatf("sat%0d.ld", k));
      apply(use8(32'(exp_perf)), $sformatf("sat%0d.use", k));
    end

    // Reset arriving while a load-use stall is being raised.
    apply(ld8(7), "rs.ld");
    @(negedge clk);
    drive(use8(0));
    reset = 1'b1;
    #1;
    check("rs.stall_before", 32'(hazard_stall), 1);
    @(posedge clk);
    #1;
    check("rs.valid", 32'(ex_valid), 0);
    check("rs.stall_after", 32'(hazard_stall), 0);
    check("rs.perf", 32'(perf_stalls), 0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
